// File: rtl/violet_pattern_gen_if.sv
// LED/display pattern generator bundle: control inputs and pattern outputs.
// Latency: none (wires only).
// Backpressure: none; outputs are free-running registers sampled by the consumer.
interface violet_pattern_gen_if #(
    parameter int WIDTH      = 16,
    parameter int DISP_WIDTH = 16
);
    logic                  i_dir;
    logic                  i_pause;
    logic [2:0]            i_speed;
    logic                  i_mode_btn;
    logic [WIDTH-1:0]      o_leds;
    logic [DISP_WIDTH-1:0] o_display;
    logic [1:0]            o_mode;
    logic                  o_tick;

    // Driver of the controls, consumer of the pattern.
    modport master (
        output i_dir, i_pause, i_speed, i_mode_btn,
        input  o_leds, o_display, o_mode, o_tick
    );

    // The pattern generator itself.
    modport slave (
        input  i_dir, i_pause, i_speed, i_mode_btn,
        output o_leds, o_display, o_mode, o_tick
    );
endinterface

// File: rtl/violet_pattern_gen.sv
// Four-mode LED pattern generator (chase/bounce/count/fill) with step counter display.
// Latency: outputs update one clock after the divider's tick condition; o_tick marks that edge.
// Backpressure: none; i_pause freezes divider and pattern, mode button still honoured.
module violet_pattern_gen #(
    parameter int WIDTH      = 16,
    parameter int DISP_WIDTH = 16,
    parameter int CLK_FREQ   = 25000000,
    parameter int STEP_HZ    = 10
) (
    input  logic                  i_clk,
    input  logic                  nrst,
    violet_pattern_gen_if.slave   bus
);
    localparam int BASE_PERIOD = CLK_FREQ / STEP_HZ;
    localparam int CNT_W       = $clog2(BASE_PERIOD + 1);
    localparam logic [CNT_W-1:0] BASE_P = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  btn_prev_q, btn_prev_d;
    logic [1:0]            mode_q, mode_d;
    logic [WIDTH-1:0]      leds_q, leds_d;
    logic [DISP_WIDTH-1:0] disp_q, disp_d;
    logic                  tick_q, tick_d;
    logic                  bdir_q, bdir_d;   // bounce direction: 0 = towards MSB

    logic [CNT_W-1:0]      period_c;
    logic                  tick_c;
    logic                  edge_c;

    // Chase and bounce start from a single lit LED; count and fill start empty.
    function automatic logic [WIDTH-1:0] mode_init(input logic [1:0] m);
        return m[1] ? '0 : WIDTH'(1);
    endfunction

    // Divider period from speed select; ">=" lets a speed-up tick at once instead of wrapping.
    always_comb begin
        period_c = BASE_P >> bus.i_speed;
        if (period_c == '0) begin
            period_c = ONE;
        end
        tick_c = !bus.i_pause && (cnt_q >= period_c - ONE);
        edge_c = bus.i_mode_btn && !btn_prev_q;
    end

    // Next-state: divider, mode cycling and per-tick pattern step (mode change beats the step).
    always_comb begin
        cnt_d      = cnt_q;
        btn_prev_d = bus.i_mode_btn;
        mode_d     = mode_q;
        leds_d     = leds_q;
        disp_d     = disp_q;
        tick_d     = tick_c;
        bdir_d     = bdir_q;

        if (!bus.i_pause) begin
            cnt_d = tick_c ? '0 : cnt_q + ONE;
        end

        if (tick_c) begin
            disp_d = bus.i_dir ? disp_q - DISP_WIDTH'(1) : disp_q + DISP_WIDTH'(1);
        end

        if (edge_c) begin
            mode_d = mode_q + 2'd1;
            leds_d = mode_init(mode_q + 2'd1);
            bdir_d = 1'b0;
        end else if (tick_c) begin
            case (mode_q)
                2'd0: leds_d = bus.i_dir ? {leds_q[0], leds_q[WIDTH-1:1]}
                                         : {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
                2'd1: begin
                    if (!bdir_q && leds_q[WIDTH-1]) begin
                        bdir_d = 1'b1;
                        leds_d = leds_q >> 1;
                    end else if (bdir_q && leds_q[0]) begin
                        bdir_d = 1'b0;
                        leds_d = leds_q << 1;
                    end else begin
                        leds_d = bdir_q ? leds_q >> 1 : leds_q << 1;
                    end
                end
                2'd2: leds_d = bus.i_dir ? leds_q - WIDTH'(1) : leds_q + WIDTH'(1);
                default: leds_d = bus.i_dir ? {~leds_q[0], leds_q[WIDTH-1:1]}
                                            : {leds_q[WIDTH-2:0], ~leds_q[WIDTH-1]};
            endcase
        end
    end

    // State registers; btn_prev resets high so a button held through reset does not count.
    always_ff @(posedge i_clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q      <= '0;
            btn_prev_q <= 1'b1;
            mode_q     <= 2'd0;
            leds_q     <= WIDTH'(1);
            disp_q     <= '0;
            tick_q     <= 1'b0;
            bdir_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            btn_prev_q <= btn_prev_d;
            mode_q     <= mode_d;
            leds_q     <= leds_d;
            disp_q     <= disp_d;
            tick_q     <= tick_d;
            bdir_q     <= bdir_d;
        end
    end

    assign bus.o_leds    = leds_q;
    assign bus.o_display = disp_q;
    assign bus.o_mode    = mode_q;
    assign bus.o_tick    = tick_q;
endmodule

// File: tb/tb_violet_pattern_gen.sv
// Bench for violet_pattern_gen: directed scenarios plus random controls against a position-based model.
// Latency: model predicts outputs after each edge; compared on every falling edge.
// Backpressure: n/a.
module tb_violet_pattern_gen;
    localparam int W = 8;
    localparam int DW = 16;

    logic i_clk;
    logic nrst;
    int   checks = 0;
    int   errors = 0;

    violet_pattern_gen_if #(.WIDTH(W), .DISP_WIDTH(DW)) bus ();

    violet_pattern_gen #(
        .WIDTH(W), .DISP_WIDTH(DW), .CLK_FREQ(100), .STEP_HZ(10)
    ) dut (
        .i_clk (i_clk),
        .nrst  (nrst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Patterns are tracked as abstract positions: a lit-LED index for chase/bounce,
    // an integer for count and a step index 0..2W-1 around the Johnson ring for fill.
    int m_cnt = 0, m_mode = 0, m_pos = 0, m_up = 1, m_val = 0, m_k = 0, m_disp = 0;
    int m_tick = 0, m_btn_prev = 1;

    function automatic int fill_val(input int k);
        if (k <= W) return (1 << k) - 1;
        return ((1 << W) - 1) & ~((1 << (k - W)) - 1);
    endfunction

    function automatic int exp_leds();
        case (m_mode)
            0, 1:    return 1 << m_pos;
            2:       return m_val;
            default: return fill_val(m_k);
        endcase
    endfunction

    always @(posedge i_clk or negedge nrst) begin
        int period;
        int tk;
        int ed;
        if (!nrst) begin
            m_cnt = 0; m_mode = 0; m_pos = 0; m_up = 1; m_val = 0; m_k = 0;
            m_disp = 0; m_tick = 0; m_btn_prev = 1;
        end else begin
            period = 10 >> bus.i_speed;
            if (period < 1) period = 1;
            tk = (!bus.i_pause && m_cnt >= period - 1) ? 1 : 0;
            ed = (bus.i_mode_btn && !m_btn_prev) ? 1 : 0;
            m_btn_prev = bus.i_mode_btn;
            if (!bus.i_pause) m_cnt = tk ? 0 : m_cnt + 1;
            m_tick = tk;
            if (tk) m_disp = (m_disp + (bus.i_dir ? (1 << DW) - 1 : 1)) % (1 << DW);
            if (ed) begin
                m_mode = (m_mode + 1) % 4;
                m_pos = 0; m_up = 1; m_val = 0; m_k = 0;
            end else if (tk) begin
                case (m_mode)
                    0: m_pos = bus.i_dir ? (m_pos + W - 1) % W : (m_pos + 1) % W;
                    1: begin
                        if (m_up && m_pos == W - 1) m_up = 0;
                        else if (!m_up && m_pos == 0) m_up = 1;
                        m_pos = m_up ? m_pos + 1 : m_pos - 1;
                    end
                    2: m_val = (m_val + (bus.i_dir ? (1 << W) - 1 : 1)) % (1 << W);
                    default: m_k = bus.i_dir ? (m_k + 2 * W - 1) % (2 * W) : (m_k + 1) % (2 * W);
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge i_clk) begin
        chk("cyc_leds", 32'(bus.o_leds), 32'(exp_leds()));
        chk("cyc_disp", 32'(bus.o_display), 32'(m_disp));
        chk("cyc_mode", 32'(bus.o_mode), 32'(m_mode));
        chk("cyc_tick", 32'(bus.o_tick), 32'(m_tick));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_tick(input int budget, input string nm);
        int n = 0;
        do begin
            cyc(1);
            n++;
        end while (bus.o_tick !== 1'b1 && n < budget);
        chk(nm, 32'(bus.o_tick), 32'd1);
    endtask

    task automatic reset_dut();
        @(posedge i_clk); #1;
        nrst = 1'b0;
        cyc(2);
        nrst = 1'b1;
    endtask

    task automatic pulse_btn();
        bus.i_mode_btn = 1'b1;
        cyc(1);
        bus.i_mode_btn = 1'b0;
    endtask

    logic [7:0] bseq [15];
    logic [7:0] fseq [16];

    initial begin
        int n;
        int pre;
        bseq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        fseq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        nrst = 1'b0;
        bus.i_dir = 1'b0; bus.i_pause = 1'b0; bus.i_speed = 3'd0; bus.i_mode_btn = 1'b0;

        // Reset values, then first tick ten cycles after release.
        cyc(2);
        chk("rst_leds", 32'(bus.o_leds), 32'h01);
        chk("rst_disp", 32'(bus.o_display), 32'h0);
        chk("rst_mode", 32'(bus.o_mode), 32'h0);
        chk("rst_tick", 32'(bus.o_tick), 32'h0);
        nrst = 1'b1;
        cyc(9);
        chk("no_early_tick", 32'(bus.o_tick), 32'h0);
        cyc(1);
        chk("first_tick", 32'(bus.o_tick), 32'h1);
        chk("first_leds", 32'(bus.o_leds), 32'h02);
        chk("first_disp", 32'(bus.o_display), 32'h1);
        repeat (7) wait_tick(20, "chase_tick");
        chk("chase_wrap", 32'(bus.o_leds), 32'h01);
        chk("chase_disp8", 32'(bus.o_display), 32'h8);

        // Direction from reset and mid-period direction changes.
        bus.i_dir = 1'b1;
        reset_dut();
        wait_tick(20, "dir_tick");
        chk("dir_leds1", 32'(bus.o_leds), 32'h80);
        chk("dir_disp1", 32'(bus.o_display), 32'hFFFF);
        wait_tick(20, "dir_tick");
        chk("dir_leds2", 32'(bus.o_leds), 32'h40);
        chk("dir_disp2", 32'(bus.o_display), 32'hFFFE);
        bus.i_dir = 1'b0;
        wait_tick(20, "dir_tick");
        chk("dir_flip_leds", 32'(bus.o_leds), 32'h80);
        chk("dir_flip_disp", 32'(bus.o_display), 32'hFFFF);
        bus.i_dir = 1'b1;
        cyc(3);
        bus.i_dir = 1'b0;
        wait_tick(20, "dir_tick");
        chk("dir_glitch_leds", 32'(bus.o_leds), 32'h01);
        chk("dir_glitch_disp", 32'(bus.o_display), 32'h0);

        // Bounce: i_dir randomised, must not matter.
        pulse_btn();
        chk("bounce_mode", 32'(bus.o_mode), 32'h1);
        chk("bounce_init", 32'(bus.o_leds), 32'h01);
        for (int i = 0; i < 15; i++) begin
            bus.i_dir = 1'($urandom);
            wait_tick(20, "bounce_tick");
            chk("bounce_seq", 32'(bus.o_leds), 32'(bseq[i]));
        end

        // Count down from zero, then Johnson fill up.
        bus.i_dir = 1'b1;
        pulse_btn();
        chk("count_mode", 32'(bus.o_mode), 32'h2);
        chk("count_init", 32'(bus.o_leds), 32'h00);
        wait_tick(20, "count_tick");
        chk("count_dn", 32'(bus.o_leds), 32'hFF);
        bus.i_dir = 1'b0;
        pulse_btn();
        chk("fill_mode", 32'(bus.o_mode), 32'h3);
        chk("fill_init", 32'(bus.o_leds), 32'h00);
        for (int i = 0; i < 16; i++) begin
            wait_tick(20, "fill_tick");
            chk("fill_seq", 32'(bus.o_leds), 32'(fseq[i]));
        end

        // Pause freezes everything.
        bus.i_pause = 1'b1;
        n = 0;
        repeat (50) begin
            cyc(1);
            if (bus.o_tick) n++;
        end
        chk("pause_ticks", 32'(n), 32'd0);
        chk("pause_leds", 32'(bus.o_leds), 32'h00);
        bus.i_pause = 1'b0;

        // Speed select.
        bus.i_speed = 3'd1;
        wait_tick(20, "spd1_sync");
        n = 0;
        do begin cyc(1); n++; end while (bus.o_tick !== 1'b1 && n < 20);
        chk("spd1_period", 32'(n), 32'd5);
        bus.i_speed = 3'd7;
        wait_tick(20, "spd7_sync");
        repeat (5) begin
            cyc(1);
            chk("spd7_every", 32'(bus.o_tick), 32'h1);
        end
        bus.i_speed = 3'd0;
        wait_tick(20, "spd0_sync");
        cyc(7);
        chk("cnt7_no_tick", 32'(bus.o_tick), 32'h0);
        bus.i_speed = 3'd2;
        cyc(1);
        chk("speedup_tick", 32'(bus.o_tick), 32'h1);
        bus.i_speed = 3'd0;

        // Mode edge on the same cycle as a tick.
        wait_tick(20, "coinc_sync");
        cyc(9);
        pre = m_disp;
        bus.i_mode_btn = 1'b1;
        cyc(1);
        bus.i_mode_btn = 1'b0;
        chk("coinc_tick", 32'(bus.o_tick), 32'h1);
        chk("coinc_mode", 32'(bus.o_mode), 32'h0);
        chk("coinc_leds", 32'(bus.o_leds), 32'h01);
        chk("coinc_disp", 32'(bus.o_display), 32'((pre + 1) % (1 << DW)));

        // Button held through reset release.
        bus.i_mode_btn = 1'b1;
        reset_dut();
        cyc(5);
        chk("held_btn_mode", 32'(bus.o_mode), 32'h0);
        bus.i_mode_btn = 1'b0;

        // Asynchronous reset in the middle of a period.
        pulse_btn();
        wait_tick(20, "async_sync");
        chk("async_pre_leds", 32'(bus.o_leds), 32'h02);
        @(posedge i_clk); #3;
        nrst = 1'b0;
        #1;
        chk("async_leds", 32'(bus.o_leds), 32'h01);
        chk("async_disp", 32'(bus.o_display), 32'h0);
        chk("async_mode", 32'(bus.o_mode), 32'h0);
        chk("async_tick", 32'(bus.o_tick), 32'h0);
        @(posedge i_clk); #1;
        nrst = 1'b1;

        // Random controls, checked each cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            bus.i_dir      = 1'($urandom);
            bus.i_pause    = ($urandom_range(0, 7) == 0);
            bus.i_mode_btn = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) bus.i_speed = 3'($urandom);
            nrst = ($urandom_range(0, 499) != 0);
            cyc(1);
        end
        nrst = 1'b1;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
